fma_32_operand_collector: RTL and testbench
===========================================

FMA_32_OPERAND_COLLECTOR -- requirements
Module: fma_32_operand_collector

Interface
REQ-001 SHALL have parameter TAG_W, default 4: width of the sequence tag attached to each issued triple.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: upstream word valid.
REQ-005 SHALL have port in_ready, output, 1: collector accepts the word this cycle.
REQ-006 SHALL have port in_data, input, 32: FP32 word (sign, 8-bit exponent, 23-bit fraction), delivered in order a, b, c.
REQ-007 SHALL have port in_acc, input, 1: sampled only on the c word; 1 = substitute feedback result for c.
REQ-008 SHALL have port flush, input, 1: discard the partially collected triple.
REQ-009 SHALL have port fb_valid, input, 1: fb_result holds a usable previous FMA result.
REQ-010 SHALL have port fb_result, input, 32: previous FMA result, for accumulate.
REQ-011 SHALL have port out_valid, output, 1: triple valid toward the FMA stage.
REQ-012 SHALL have port out_ready, input, 1: FMA stage consumes the triple.
REQ-013 SHALL have ports out_a, out_b, out_c, output, 32 each: registered operands.
REQ-014 SHALL have port out_tag, output, TAG_W: sequence number of the presented triple.

Function
REQ-015 SHALL implement the states S_A, S_B, S_C, S_FULL; in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-016 S_A: in_ready=1; in_fire latches in_data into the a register and goes to S_B.
REQ-017 S_B: in_ready=1; in_fire latches into the b register and goes to S_C.
REQ-018 S_C: in_ready = ~in_acc | fb_valid; in_fire latches c (in_data if in_acc=0, else fb_result sampled that cycle), sets out_valid and goes to S_FULL.
REQ-019 S_C with in_valid=1, in_acc=1 and fb_valid=0: in_ready=0, no state change, and the stall lasts until fb_valid rises.
REQ-020 S_FULL: out_valid=1 and out_a/b/c/tag are held stable until out_fire.
REQ-021 S_FULL: in_ready = out_ready; on out_fire without in_fire go to S_A.
REQ-022 S_FULL with out_fire and in_fire in the same cycle: latch in_data as the new a, clear out_valid, and go to S_B; no bubble and no lost word.
REQ-023 out_valid SHALL be registered; it is 1 exactly in S_FULL.
REQ-024 out_tag SHALL start at 0, increment modulo 2^TAG_W on each out_fire, and wrap from 2^TAG_W-1 to 0.
REQ-025 Operands SHALL pass bit-exact; no classification or modification (denormals, NaN and Inf forwarded untouched).
REQ-026 flush in S_A/S_B/S_C: next state S_A, and in_fire in the same cycle is ignored (in_ready forced 0 while flush=1).
REQ-027 flush in S_FULL: the held triple is kept; flush has no effect on issued data.
REQ-028 Outputs SHALL not change while out_valid=1 and out_ready=0, regardless of in_valid, fb_valid or flush.

Reset
REQ-029 On rst=1 at a rising edge, the block SHALL enter S_A with out_valid=0, out_tag=0, and out_a/out_b/out_c=32'h0.
REQ-030 Reset SHALL take priority over flush, in_fire and out_fire, including mid-triple and while in S_FULL (the held triple is dropped).
REQ-031 in_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset deassertion.

Verification
REQ-032 Basic: words 3F800000, 40000000, 40400000 with in_acc=0 and out_ready=1 -> out_valid on the cycle after the third fire, out_a/b/c equal to those words, out_tag=0.
REQ-033 Accumulate stall: c word with in_acc=1 and fb_valid=0 for 5 cycles, then fb_valid=1 with fb_result=41200000 -> in_ready=0 for 5 cycles, then out_c=41200000.
REQ-034 Back-pressure plus overlap: out_ready=0 for 3 cycles in S_FULL with the next a waiting -> outputs stable; when out_ready=1, the same-cycle fire moves the new a in, out_valid drops, and the state is S_B.
REQ-035 Flush: a and b accepted, flush=1 with in_valid=1 -> word ignored, state S_A; the next three words form a clean triple.
REQ-036 Tag wrap: 17 back-to-back triples with TAG_W=4 -> tags 0..15, then 0.
REQ-037 Reset mid-operation: rst asserted in S_C and again in S_FULL -> out_valid=0, out_tag=0 the next cycle, and the following triple is issued with tag 0.

Source files
------------

// File: rtl/fma_32_operand_collector.sv
// fma_32_operand_collector: gathers a/b/c FP32 words (c optionally replaced by FMA feedback) into a tagged triple
module fma_32_operand_collector #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_acc,
    input  logic             flush,
    input  logic             fb_valid,
    input  logic [31:0]      fb_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [31:0]      out_c,
    output logic [TAG_W-1:0] out_tag
);
    typedef enum logic [1:0] {S_A, S_B, S_C, S_FULL} state_t;
    state_t state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic valid_q, in_fire, out_fire;
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        out_fire = valid_q & out_ready;
        tag_d    = tag_q + TAG_W'(out_fire);
        // flush only blocks intake while a triple is still being assembled
        in_ready = rst ? 1'b0 :
                   state_q == S_FULL ? out_ready :
                   flush ? 1'b0 :
                   state_q == S_C ? (~in_acc | fb_valid) : 1'b1;
        in_fire  = in_valid & in_ready;
        case (state_q)
            S_A: if (in_fire) begin
                a_d     = in_data;
                state_d = S_B;
            end
            S_B: if (in_fire) begin
                b_d     = in_data;
                state_d = S_C;
            end
            S_C: if (in_fire) begin
                c_d     = in_acc ? fb_result : in_data;
                state_d = S_FULL;
            end
            default: if (out_fire) begin
                a_d     = in_fire ? in_data : a_q;
                state_d = in_fire ? S_B : S_A;
            end
        endcase
        if (flush && state_q != S_FULL) state_d = S_A;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            valid_q <= 1'b0;
            tag_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= state_d == S_FULL;
            tag_q   <= tag_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end
    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_c     = c_q;
    assign out_tag   = tag_q;
endmodule

// File: tb/tb_fma_32_operand_collector.sv
// tb_fma_32_operand_collector: directed scenarios plus random traffic against a word-count reference model
module tb_fma_32_operand_collector;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_acc = 1'b0, flush = 1'b0;
    logic fb_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
    logic [31:0] in_data = '0, fb_result = '0, out_a, out_b, out_c;
    logic [3:0] out_tag;
    int n_vec = 0, n_err = 0;
    int m_cnt = 0;
    bit m_init = 0;
    logic [31:0] m_w[3];
    logic [3:0] m_tag = '0;

    fma_32_operand_collector #(.TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_acc(in_acc), .flush(flush), .fb_valid(fb_valid), .fb_result(fb_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_c(out_c), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model at posedge
    task automatic step(input logic r, input logic v, input logic [31:0] d, input logic acc,
                        input logic fl, input logic fv, input logic [31:0] fr, input logic ordy);
        logic er, ifire, ofire;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; in_acc = acc;
        flush = fl; fb_valid = fv; fb_result = fr; out_ready = ordy;
        #1;
        er = r ? 1'b0 : m_cnt == 3 ? ordy : fl ? 1'b0 : m_cnt == 2 ? (!acc || fv) : 1'b1;
        chk("in_ready", {31'b0, in_ready}, {31'b0, er});
        if (m_init) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_cnt == 3});
            chk("out_tag", {28'b0, out_tag}, {28'b0, m_tag});
            if (m_cnt == 3) begin
                chk("out_a", out_a, m_w[0]);
                chk("out_b", out_b, m_w[1]);
                chk("out_c", out_c, m_w[2]);
            end
        end
        ifire = v & er;
        ofire = m_cnt == 3 && ordy;
        @(posedge clk);
        if (r) begin
            m_init = 1; m_cnt = 0; m_tag = '0;
            m_w[0] = '0; m_w[1] = '0; m_w[2] = '0;
        end else begin
            if (ofire) m_tag = m_tag + 4'd1;
            if (m_cnt == 3) begin
                if (ofire) begin
                    m_cnt = ifire ? 1 : 0;
                    if (ifire) m_w[0] = d;
                end
            end else if (fl) m_cnt = 0;
            else if (ifire) begin
                m_w[m_cnt] = (m_cnt == 2 && acc) ? fr : d;
                m_cnt++;
            end
        end
    endtask

    task automatic word(input logic [31:0] d, input logic ordy);
        step(0, 1, d, 0, 0, 0, 32'h0, ordy);
    endtask

    task automatic idle(input logic ordy);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0, ordy);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_tag", {28'b0, out_tag}, 32'd0);
        chk("rst_a", out_a, 32'h0);
        chk("rst_c", out_c, 32'h0);
        // basic triple
        word(32'h3F800000, 1); word(32'h40000000, 1); word(32'h40400000, 1);
        #1;
        chk("basic_valid", {31'b0, out_valid}, 32'd1);
        chk("basic_a", out_a, 32'h3F800000);
        chk("basic_b", out_b, 32'h40000000);
        chk("basic_c", out_c, 32'h40400000);
        chk("basic_tag", {28'b0, out_tag}, 32'd0);
        idle(1);
        // accumulate stall
        word(32'h7F800001, 1); word(32'h00000001, 1);
        repeat (5) step(0, 1, 32'hDEADBEEF, 1, 0, 0, 32'h0, 1);
        step(0, 1, 32'hDEADBEEF, 1, 0, 1, 32'h41200000, 1);
        #1;
        chk("acc_c", out_c, 32'h41200000);
        chk("acc_a", out_a, 32'h7F800001);
        // back-pressure then overlapping fire
        repeat (3) word(32'h11111111, 0);
        word(32'h11111111, 1);
        #1;
        chk("ovl_valid", {31'b0, out_valid}, 32'd0);
        word(32'h22222222, 1); word(32'h33333333, 1);
        #1;
        chk("ovl_a", out_a, 32'h11111111);
        chk("ovl_c", out_c, 32'h33333333);
        idle(1);
        // flush mid-triple
        word(32'hAAAAAAAA, 1); word(32'hBBBBBBBB, 1);
        step(0, 1, 32'hCCCCCCCC, 0, 1, 0, 32'h0, 1);
        word(32'h01020304, 1); word(32'h05060708, 1); word(32'h090A0B0C, 1);
        #1;
        chk("flush_a", out_a, 32'h01020304);
        chk("flush_c", out_c, 32'h090A0B0C);
        idle(1);
        // tag wrap over 17 back-to-back triples
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            word(32'h1000 + i, 1); word(32'h2000 + i, 1); word(32'h3000 + i, 1);
            #1;
            chk("wrap_tag", {28'b0, out_tag}, i % 16);
        end
        idle(1);
        // reset in S_C and in S_FULL
        word(32'h1, 1); word(32'h2, 1);
        step(1, 1, 32'h3, 0, 0, 0, 0, 1);
        #1;
        chk("rstc_valid", {31'b0, out_valid}, 32'd0);
        chk("rstc_tag", {28'b0, out_tag}, 32'd0);
        word(32'h4, 1); word(32'h5, 1); word(32'h6, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rstf_valid", {31'b0, out_valid}, 32'd0);
        chk("rstf_tag", {28'b0, out_tag}, 32'd0);
        word(32'h7, 1); word(32'h8, 1); word(32'h9, 1);
        #1;
        chk("rst_next_tag", {28'b0, out_tag}, 32'd0);
        chk("rst_next_a", out_a, 32'h7);
        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
